// File: rtl/rom_access_sequencer_if.sv
// -----------------------------------------------------------------------------
// rom_access_sequencer_if
//   Bundles the three buses of rom_access_sequencer:
//     - SNES side : read/write strobes, decoder qualifiers, write data in,
//                   read data out with a one-cycle valid pulse.
//     - MCU side  : level request with write flag, address and write data;
//                   read data out with a one-cycle ack pulse.
//     - Chip side : 23-bit word address, 16-bit data in/out with output
//                   enable, and the active-low OE/WE/BHE/BLE strobes.
//   Modports:
//     slave  - the sequencer (consumes requests, drives the chip pins)
//     master - the environment (decoder, MCU and the SRAM chip)
// -----------------------------------------------------------------------------
interface rom_access_sequencer_if;

  // SNES side
  logic        snes_rd_strobe;
  logic        snes_wr_strobe;
  logic [23:0] snes_rom_addr;
  logic        rom_hit;
  logic        is_writable;
  logic [7:0]  snes_data_in;
  logic [7:0]  snes_data_out;
  logic        snes_data_valid;

  // MCU side
  logic        mcu_rq;
  logic        mcu_write;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_dout;
  logic [7:0]  mcu_din;
  logic        mcu_ack;

  // Chip side
  logic [22:0] rom_a;
  logic [15:0] rom_dq_in;
  logic [15:0] rom_dq_out;
  logic        rom_dq_oe;
  logic        rom_oe_n;
  logic        rom_we_n;
  logic        rom_bhe_n;
  logic        rom_ble_n;

  modport slave (
    input  snes_rd_strobe, snes_wr_strobe, snes_rom_addr, rom_hit, is_writable,
           snes_data_in, mcu_rq, mcu_write, mcu_addr, mcu_dout, rom_dq_in,
    output snes_data_out, snes_data_valid, mcu_din, mcu_ack, rom_a, rom_dq_out,
           rom_dq_oe, rom_oe_n, rom_we_n, rom_bhe_n, rom_ble_n
  );

  modport master (
    output snes_rd_strobe, snes_wr_strobe, snes_rom_addr, rom_hit, is_writable,
           snes_data_in, mcu_rq, mcu_write, mcu_addr, mcu_dout, rom_dq_in,
    input  snes_data_out, snes_data_valid, mcu_din, mcu_ack, rom_a, rom_dq_out,
           rom_dq_oe, rom_oe_n, rom_we_n, rom_bhe_n, rom_ble_n
  );

endinterface

// File: rtl/rom_access_sequencer.sv
// -----------------------------------------------------------------------------
// rom_access_sequencer
//   Runs byte-wide accesses on the 16-bit external ROM/SRAM chip on behalf of
//   the SNES address decoder and the MCU. SNES cycles have strict priority; a
//   one-entry pending slot holds an SNES request that arrives while another
//   access is on the chip. Each access takes IDLE -> READ/WRITE (fixed wait
//   states) -> DONE -> IDLE.
//
//   Parameters:
//     RD_CYCLES - cycles ROM_OE_N is held low before data capture (2..15)
//     WR_CYCLES - cycles ROM_WE_N is held low per write (2..15)
//   Ports:
//     clk - system clock
//     rst - synchronous, active-high reset
//     bus - rom_access_sequencer_if.slave (SNES, MCU and chip signals)
// -----------------------------------------------------------------------------
module rom_access_sequencer #(
  parameter int unsigned RD_CYCLES = 6,
  parameter int unsigned WR_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rom_access_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;

  // One-entry SNES pending slot
  logic        pend_valid_q;
  logic        pend_write_q;
  logic [23:0] pend_addr_q;
  logic [7:0]  pend_data_q;

  // Operation in flight; drives ROM_A / ROM_DQ_OUT for the whole op
  logic        op_write_q;
  logic        op_mcu_q;
  logic [23:0] op_addr_q;
  logic [7:0]  op_data_q;

  logic [7:0]  snes_data_q;
  logic [7:0]  mcu_din_q;

  // Strobe qualification; a simultaneous read strobe suppresses the write
  logic        rd_qual, wr_qual, snes_new;
  logic        snes_write_sel;
  logic [23:0] snes_addr_sel;
  logic [7:0]  snes_data_sel;

  assign rd_qual  = bus.snes_rd_strobe & bus.rom_hit;
  assign wr_qual  = bus.snes_wr_strobe & bus.rom_hit & bus.is_writable & ~bus.snes_rd_strobe;
  assign snes_new = rd_qual | wr_qual;

  // A strobe arriving in IDLE is served directly and supersedes the slot,
  // matching the overwrite rule for a second strobe before service.
  assign snes_write_sel = snes_new ? wr_qual           : pend_write_q;
  assign snes_addr_sel  = snes_new ? bus.snes_rom_addr : pend_addr_q;
  assign snes_data_sel  = snes_new ? bus.snes_data_in  : pend_data_q;

  logic start_snes, start_mcu, last_cycle;
  logic oe_n, we_n, bhe_n, ble_n, dq_oe, snes_valid, mcu_ack;
  logic [7:0] rd_byte;

  assign rd_byte = op_addr_q[0] ? bus.rom_dq_in[15:8] : bus.rom_dq_in[7:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_d    = state_q;
    start_snes = 1'b0;
    start_mcu  = 1'b0;
    last_cycle = 1'b0;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    bhe_n      = 1'b1;
    ble_n      = 1'b1;
    dq_oe      = 1'b0;
    snes_valid = 1'b0;
    mcu_ack    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_valid_q || snes_new) begin
          start_snes = 1'b1;
          state_d    = snes_write_sel ? WRITE : READ;
        end else if (bus.mcu_rq) begin
          start_mcu  = 1'b1;
          state_d    = bus.mcu_write ? WRITE : READ;
        end
      end
      READ: begin
        oe_n       = 1'b0;
        bhe_n      = ~op_addr_q[0];
        ble_n      = op_addr_q[0];
        last_cycle = (cnt_q == RD_LAST);
        if (last_cycle) state_d = DONE;
      end
      WRITE: begin
        we_n       = 1'b0;
        dq_oe      = 1'b1;
        bhe_n      = ~op_addr_q[0];
        ble_n      = op_addr_q[0];
        last_cycle = (cnt_q == WR_LAST);
        if (last_cycle) state_d = DONE;
      end
      DONE: begin
        // Keep driving the bus one extra cycle after a write for data hold
        dq_oe      = op_write_q;
        snes_valid = ~op_mcu_q & ~op_write_q;
        mcu_ack    = op_mcu_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_write_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      op_write_q   <= 1'b0;
      op_mcu_q     <= 1'b0;
      op_addr_q    <= '0;
      op_data_q    <= '0;
      snes_data_q  <= '0;
      mcu_din_q    <= '0;
    end else begin
      // Wait-state counter runs only inside READ/WRITE and restarts at 0
      if ((state_q == READ || state_q == WRITE) && !last_cycle) cnt_q <= cnt_q + 4'd1;
      else                                                     cnt_q <= '0;

      // Strobes arriving outside IDLE park in the slot; IDLE always drains it
      if (snes_new && state_q != IDLE) begin
        pend_valid_q <= 1'b1;
        pend_write_q <= wr_qual;
        pend_addr_q  <= bus.snes_rom_addr;
        pend_data_q  <= bus.snes_data_in;
      end else if (start_snes) begin
        pend_valid_q <= 1'b0;
      end

      if (start_snes) begin
        op_write_q <= snes_write_sel;
        op_mcu_q   <= 1'b0;
        op_addr_q  <= snes_addr_sel;
        op_data_q  <= snes_data_sel;
      end else if (start_mcu) begin
        op_write_q <= bus.mcu_write;
        op_mcu_q   <= 1'b1;
        op_addr_q  <= bus.mcu_addr;
        op_data_q  <= bus.mcu_dout;
      end

      // Read data captured on the last OE-low edge
      if (state_q == READ && last_cycle) begin
        if (op_mcu_q) mcu_din_q   <= rd_byte;
        else          snes_data_q <= rd_byte;
      end
    end
  end

  assign bus.rom_a           = op_addr_q[23:1];
  assign bus.rom_dq_out      = {op_data_q, op_data_q};
  assign bus.rom_dq_oe       = dq_oe;
  assign bus.rom_oe_n        = oe_n;
  assign bus.rom_we_n        = we_n;
  assign bus.rom_bhe_n       = bhe_n;
  assign bus.rom_ble_n       = ble_n;
  assign bus.snes_data_out   = snes_data_q;
  assign bus.snes_data_valid = snes_valid;
  assign bus.mcu_din         = mcu_din_q;
  assign bus.mcu_ack         = mcu_ack;

endmodule

// File: tb/tb_rom_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rom_access_sequencer
//   Directed bench for rom_access_sequencer. Stimulus pushes the expected
//   {source, data, cycle} of every SNES_DATA_VALID / MCU_ACK into a queue; an
//   independent monitor pops and compares whenever either pulse appears.
//   Pin activity (OE/WE/DQ_OE low/high cycle counts, lanes, address, data)
//   is checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_rom_access_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    bit         is_mcu;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];

  rom_access_sequencer_if bus ();

  rom_access_sequencer #(.RD_CYCLES(6), .WR_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every response pulse against the scoreboard head
  always @(negedge clk) begin
    if (bus.snes_data_valid || bus.mcu_ack) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: valid=%0b ack=%0b with nothing expected (cycle %0d)",
                 bus.snes_data_valid, bus.mcu_ack, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_source", {31'd0, bus.mcu_ack}, {31'd0, e.is_mcu});
        check("sb_cycle", cyc, e.cyc);
        check("sb_data", e.is_mcu ? bus.mcu_din : bus.snes_data_out, e.data);
      end
    end
  end

  // Samples n cycles starting at the current negedge
  task automatic observe(input int n, output int oe_lo, output int we_lo, output int dqoe_hi);
    oe_lo = 0; we_lo = 0; dqoe_hi = 0;
    for (int i = 0; i < n; i++) begin
      if (!bus.rom_oe_n)  oe_lo++;
      if (!bus.rom_we_n)  we_lo++;
      if (bus.rom_dq_oe)  dqoe_hi++;
      @(negedge clk);
    end
  endtask

  // MCU master: raise RQ now, wait (bounded) for ACK, drop RQ the cycle after
  task automatic mcu_op(input logic wr, input logic [23:0] addr, input logic [7:0] dout);
    bit seen;
    seen = 1'b0;
    bus.mcu_rq    = 1'b1;
    bus.mcu_write = wr;
    bus.mcu_addr  = addr;
    bus.mcu_dout  = dout;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.mcu_ack) seen = 1'b1;
    end
    check("mcu_ack_seen", {31'd0, seen}, 32'd1);
    if (seen && wr) begin
      check("mcu_wr_dq_out", bus.rom_dq_out, {dout, dout});
      check("mcu_wr_rom_a", bus.rom_a, addr[23:1]);
    end
    @(negedge clk);
    bus.mcu_rq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int oe_lo, we_lo, dqoe_hi, c;

    rst                = 1'b1;
    bus.snes_rd_strobe = 1'b0;
    bus.snes_wr_strobe = 1'b0;
    bus.snes_rom_addr  = '0;
    bus.rom_hit        = 1'b0;
    bus.is_writable    = 1'b0;
    bus.snes_data_in   = '0;
    bus.mcu_rq         = 1'b0;
    bus.mcu_write      = 1'b0;
    bus.mcu_addr       = '0;
    bus.mcu_dout       = '0;
    bus.rom_dq_in      = '0;

    // ---- Reset state ----
    repeat (3) @(negedge clk);
    check("rst_oe_n", bus.rom_oe_n, 1);
    check("rst_we_n", bus.rom_we_n, 1);
    check("rst_bhe_n", bus.rom_bhe_n, 1);
    check("rst_ble_n", bus.rom_ble_n, 1);
    check("rst_dq_oe", bus.rom_dq_oe, 0);
    check("rst_rom_a", bus.rom_a, 0);
    check("rst_dq_out", bus.rom_dq_out, 0);
    check("rst_snes_data", bus.snes_data_out, 0);
    check("rst_mcu_din", bus.mcu_din, 0);
    check("rst_valid_ack", {bus.snes_data_valid, bus.mcu_ack}, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- SNES read at 0x123457, high lane ----
    bus.rom_dq_in      = 16'hA55A;
    bus.snes_rom_addr  = 24'h123457;
    bus.rom_hit        = 1'b1;
    bus.snes_rd_strobe = 1'b1;
    sb_q.push_back('{1'b0, 8'hA5, cyc + 7});
    @(negedge clk);
    bus.snes_rd_strobe = 1'b0;
    bus.rom_hit        = 1'b0;
    check("rd_rom_a", bus.rom_a, 23'h091A2B);
    check("rd_bhe_n", bus.rom_bhe_n, 0);
    check("rd_ble_n", bus.rom_ble_n, 1);
    observe(9, oe_lo, we_lo, dqoe_hi);
    check("rd_oe_cycles", oe_lo, 6);
    check("rd_we_cycles", we_lo, 0);

    // ---- SNES write 0xE00010 <- 0x3C, writable ----
    bus.snes_rom_addr  = 24'hE00010;
    bus.snes_data_in   = 8'h3C;
    bus.rom_hit        = 1'b1;
    bus.is_writable    = 1'b1;
    bus.snes_wr_strobe = 1'b1;
    @(negedge clk);
    bus.snes_wr_strobe = 1'b0;
    bus.rom_hit        = 1'b0;
    check("wr_dq_out", bus.rom_dq_out, 16'h3C3C);
    check("wr_rom_a", bus.rom_a, 23'h700008);
    check("wr_ble_n", bus.rom_ble_n, 0);
    check("wr_bhe_n", bus.rom_bhe_n, 1);
    check("wr_we_n_c1", bus.rom_we_n, 0);
    observe(8, oe_lo, we_lo, dqoe_hi);
    check("wr_we_cycles", we_lo, 4);
    check("wr_dqoe_cycles", dqoe_hi, 5);
    check("wr_oe_cycles", oe_lo, 0);

    // ---- Same write, not writable: no chip activity ----
    bus.rom_hit        = 1'b1;
    bus.is_writable    = 1'b0;
    bus.snes_wr_strobe = 1'b1;
    @(negedge clk);
    bus.snes_wr_strobe = 1'b0;
    bus.rom_hit        = 1'b0;
    observe(8, oe_lo, we_lo, dqoe_hi);
    check("ro_activity", oe_lo + we_lo + dqoe_hi, 0);

    // ---- MCU read 0x000001 in flight, SNES read arrives ----
    bus.rom_dq_in = 16'hC396;
    c = cyc;
    sb_q.push_back('{1'b1, 8'hC3, c + 7});
    fork
      mcu_op(1'b0, 24'h000001, 8'h00);
      begin
        repeat (2) @(negedge clk);
        bus.snes_rom_addr  = 24'h000100;
        bus.rom_hit        = 1'b1;
        bus.snes_rd_strobe = 1'b1;
        sb_q.push_back('{1'b0, 8'h96, c + 15});
        @(negedge clk);
        bus.snes_rd_strobe = 1'b0;
        bus.rom_hit        = 1'b0;
      end
    join
    repeat (9) @(negedge clk);

    // ---- MCU write and SNES read in the same IDLE cycle: SNES first ----
    c = cyc;
    bus.rom_dq_in      = 16'h1234;
    bus.snes_rom_addr  = 24'h000003;
    bus.rom_hit        = 1'b1;
    bus.snes_rd_strobe = 1'b1;
    sb_q.push_back('{1'b0, 8'h12, c + 7});
    sb_q.push_back('{1'b1, 8'hC3, c + 13});
    fork
      mcu_op(1'b1, 24'h000202, 8'h5A);
      begin
        @(negedge clk);
        bus.snes_rd_strobe = 1'b0;
        bus.rom_hit        = 1'b0;
      end
    join
    repeat (10) @(negedge clk);

    // ---- Unqualified read, then RD+WR together (read only) ----
    bus.snes_rom_addr  = 24'h000010;
    bus.rom_hit        = 1'b0;
    bus.snes_rd_strobe = 1'b1;
    @(negedge clk);
    bus.snes_rd_strobe = 1'b0;
    observe(8, oe_lo, we_lo, dqoe_hi);
    check("nohit_activity", oe_lo + we_lo + dqoe_hi, 0);
    bus.rom_dq_in      = 16'hBEEF;
    bus.snes_data_in   = 8'h77;
    bus.rom_hit        = 1'b1;
    bus.is_writable    = 1'b1;
    bus.snes_rd_strobe = 1'b1;
    bus.snes_wr_strobe = 1'b1;
    sb_q.push_back('{1'b0, 8'hEF, cyc + 7});
    @(negedge clk);
    bus.snes_rd_strobe = 1'b0;
    bus.snes_wr_strobe = 1'b0;
    bus.rom_hit        = 1'b0;
    observe(9, oe_lo, we_lo, dqoe_hi);
    check("rdwr_oe_cycles", oe_lo, 6);
    check("rdwr_we_cycles", we_lo, 0);
    check("rdwr_dqoe_cycles", dqoe_hi, 0);

    // ---- RST in cycle 3 of an MCU write with an SNES read pending ----
    bus.mcu_rq    = 1'b1;
    bus.mcu_write = 1'b1;
    bus.mcu_addr  = 24'h000404;
    bus.mcu_dout  = 8'h11;
    @(negedge clk);
    check("abort_we_c1", bus.rom_we_n, 0);
    bus.snes_rom_addr  = 24'h000020;
    bus.rom_hit        = 1'b1;
    bus.snes_rd_strobe = 1'b1;
    @(negedge clk);
    bus.snes_rd_strobe = 1'b0;
    bus.rom_hit        = 1'b0;
    @(negedge clk);
    check("abort_we_c3", bus.rom_we_n, 0);
    rst        = 1'b1;
    bus.mcu_rq = 1'b0;
    @(negedge clk);
    check("abort_we_n", bus.rom_we_n, 1);
    check("abort_dq_oe", bus.rom_dq_oe, 0);
    check("abort_oe_n", bus.rom_oe_n, 1);
    rst = 1'b0;
    observe(12, oe_lo, we_lo, dqoe_hi);
    check("abort_idle_activity", oe_lo + we_lo + dqoe_hi, 0);

    repeat (3) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rom_access_sequencer.md
# rom_access_sequencer

Services the memory-access requests produced by the SNES address decoder by running the actual cycle on the 16-bit external ROM/SRAM chip. Arbitrates between SNES bus cycles (strict priority) and MCU requests, generates OE/WE/byte-lane strobes with fixed wait states, and returns read data with a valid/ack pulse. It sits between the address decoder and the SRAM0 pins.

## Interface
- RD_CYCLES, 6, cycles ROM_OE_N is held low before read data is captured (legal range 2..15)
- WR_CYCLES, 4, cycles ROM_WE_N is held low per write (legal range 2..15)

- CLK  in  1  system clock
- RST  in  1  reset; synchronous, active-high
- SNES_RD_STROBE  in  1  one-cycle pulse; SNES read cycle started, address/decode inputs valid this cycle
- SNES_WR_STROBE  in  1  one-cycle pulse; SNES write cycle, SNES_DATA_IN valid this cycle
- SNES_ROM_ADDR  in  24  byte address from the decoder
- ROM_HIT  in  1  decoder: cycle targets SRAM0
- IS_WRITABLE  in  1  decoder: target area accepts writes
- SNES_DATA_IN  in  8  SNES write data
- SNES_DATA_OUT  out  8  read data for SNES; holds until next SNES read completes
- SNES_DATA_VALID  out  1  one-cycle pulse; SNES_DATA_OUT updated
- MCU_RQ  in  1  level request; held until MCU_ACK
- MCU_WRITE  in  1  1=write, 0=read; stable while MCU_RQ
- MCU_ADDR  in  24  MCU byte address; stable while MCU_RQ
- MCU_DOUT  in  8  MCU write data
- MCU_DIN  out  8  MCU read data; holds until next MCU read completes
- MCU_ACK  out  1  one-cycle pulse; MCU op complete
- ROM_A  out  23  word address = op address[23:1]
- ROM_DQ_IN  in  16  chip data bus input
- ROM_DQ_OUT  out  16  chip write data
- ROM_DQ_OE  out  1  1=drive ROM_DQ_OUT onto pins
- ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N  out  1 each  active-low chip strobes

## Operation
- States: IDLE, READ, WRITE, DONE.
- SNES strobe qualification: read needs ROM_HIT; write needs ROM_HIT & IS_WRITABLE; unqualified strobes are dropped. RD and WR strobes together: read wins, write dropped.
- One-entry SNES pending slot latches {rd/wr, address, data} on a qualified strobe in any state; a second strobe before service overwrites it.
- IDLE: if the pending slot is full, or a qualified strobe arrives this cycle, start the SNES op (clear slot). Else if MCU_RQ, start the MCU op. Else stay.
- Byte lanes: addr[0]=0 -> low byte, ROM_BLE_N=0; addr[0]=1 -> high byte, ROM_BHE_N=0; other lane strobe stays 1. Writes replicate the byte on both halves of ROM_DQ_OUT. Reads select DQ_IN[7:0] or [15:8] by addr[0].
- READ: ROM_OE_N=0 and lane strobe low for RD_CYCLES cycles; capture on the last edge into SNES_DATA_OUT or MCU_DIN; go to DONE.
- WRITE: ROM_DQ_OE=1, ROM_WE_N=0 for WR_CYCLES cycles; go to DONE.
- DONE, one cycle: all strobes high; ROM_DQ_OE stays 1 after a write (data hold); SNES_DATA_VALID pulses for an SNES read; MCU_ACK pulses for any MCU op; SNES writes get no pulse. Return to IDLE.
- ROM_A and ROM_DQ_OUT are held for the whole op including DONE.

## Timing
- Reset: state IDLE, pending slot empty, ROM_OE_N/WE_N/BHE_N/BLE_N=1, ROM_DQ_OE=0, ROM_A=0, ROM_DQ_OUT=0, SNES_DATA_OUT=0, MCU_DIN=0, SNES_DATA_VALID=0, MCU_ACK=0. RST mid-op aborts at that edge; no valid/ack is produced for the aborted op.
- Strobe in cycle 0 while IDLE: strobes active cycles 1..N (N=RD_CYCLES or WR_CYCLES), DONE in cycle N+1, IDLE in cycle N+2.
- Read latency to SNES_DATA_VALID = RD_CYCLES+1 cycles after the strobe. Worst case with an MCU op in flight is about 2*(RD_CYCLES+2) cycles.
- MCU must drop MCU_RQ in the cycle after MCU_ACK; an RQ held high starts a new op.
- The pending slot is served before MCU_RQ in every IDLE cycle. The MCU can be starved only by back-to-back SNES strobes.

## Test plan
- SNES read at 0x123457, ROM_HIT=1, DQ_IN=0xA55A -> ROM_A=0x091A2B, BHE_N=0, BLE_N=1, OE_N low 6 cycles, SNES_DATA_VALID in cycle 7 with SNES_DATA_OUT=0xA5.
- SNES write 0xE00010 data 0x3C, IS_WRITABLE=1 -> ROM_DQ_OUT=0x3C3C, BLE_N=0, WE_N low cycles 1..4, DQ_OE high cycles 1..5, no valid pulse. Same stimulus with IS_WRITABLE=0 -> no chip activity.
- MCU read 0x000001 in flight when SNES read strobe arrives -> MCU_ACK after 7 cycles, SNES op starts in the next IDLE cycle, SNES_DATA_VALID 7 cycles after that.
- MCU_RQ and qualified SNES strobe in the same IDLE cycle -> SNES op runs first; MCU op follows; exactly one MCU_ACK.
- SNES_RD_STROBE with ROM_HIT=0, then RD+WR strobes together -> first ignored; second performs a read only.
- RST asserted in cycle 3 of a write -> next cycle WE_N=1, DQ_OE=0, state IDLE, pending slot empty, no ACK.
